// File: rtl/dcache_req_responder.sv
// dcache_req_responder: single-outstanding D$ request responder backed by a 64-bit word store.
// Optional DCACHE_RESP_GNT_STALL_EN adds an LFSR that randomly withholds grants in IDLE.
package config_pkg;
   typedef struct packed {
      int unsigned PLEN;
   } cva6_cfg_t;
   localparam cva6_cfg_t cva6_cfg_empty = '{PLEN: 56};
   typedef struct packed {
      logic [11:0] address_index;
      logic [43:0] address_tag;
      logic [63:0] data_wdata;
      logic        data_req;
      logic        data_we;
      logic [7:0]  data_be;
      logic [1:0]  data_size;
      logic [3:0]  data_id;
      logic        kill_req;
      logic        tag_valid;
   } dcache_req_i_t;
   typedef struct packed {
      logic        data_gnt;
      logic        data_rvalid;
      logic [3:0]  data_rid;
      logic [63:0] data_rdata;
      logic [0:0]  data_ruser;
   } dcache_req_o_t;
endpackage

module dcache_req_responder
   import config_pkg::*;
#(
   parameter cva6_cfg_t   CVA6Cfg    = cva6_cfg_empty,
   parameter int unsigned NR_WORDS   = 512,
   parameter logic [63:0] BASE_ADDR  = '0,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  dcache_req_i_t req_port_i,
   output dcache_req_o_t req_port_o,
   output logic          busy_o,
   output logic          err_o
);
   localparam int PLEN = CVA6Cfg.PLEN;
   localparam int AW   = $clog2(NR_WORDS);
   localparam int HI   = AW + 3;

   typedef enum logic [1:0] {IDLE, TAG, LAT} state_t;

   state_t          state, state_n;
   logic [11:0]     index_q;
   logic            we_q;
   logic [7:0]      be_q;
   logic [63:0]     wdata_q;
   logic [63:0]     rdata_q;
   logic [3:0]      id_q;
   logic [1:0]      cnt_q;
   logic [63:0]     mem [NR_WORDS];
   logic [PLEN-1:0] paddr;
   logic [AW-1:0]   word;
   logic            in_range;
   logic            gnt;
   logic            tag_go;
   logic            rvalid;
   logic            err;
   logic            stall;

`ifdef DCACHE_RESP_GNT_STALL_EN
   logic [7:0] lfsr;
   always_ff @(posedge clk_i) begin
      if (!rst_ni) lfsr <= 8'hA5;
      else         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end
   assign stall = lfsr[0];
`else
   assign stall = 1'b0;
`endif

   assign paddr    = {req_port_i.address_tag, index_q};
   assign in_range = paddr[PLEN-1:HI] == BASE_ADDR[PLEN-1:HI];
   assign word     = paddr[3 +: AW];

   always_comb begin
      state_n = state;
      gnt     = 1'b0;
      tag_go  = 1'b0;
      rvalid  = 1'b0;
      err     = 1'b0;
      case (state)
         IDLE: begin
            gnt = rst_ni & req_port_i.data_req & ~stall;
            if (gnt) state_n = TAG;
         end
         TAG: begin
            // kill takes priority over a same-cycle tag
            if (req_port_i.kill_req) state_n = IDLE;
            else if (req_port_i.tag_valid) begin
               tag_go  = rst_ni;
               err     = rst_ni & ~in_range;
               state_n = we_q ? IDLE : LAT;
            end
         end
         LAT: begin
            if (cnt_q == 2'd0) begin
               rvalid  = rst_ni;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state   <= IDLE;
         index_q <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         id_q    <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_n;
         if (gnt) begin
            index_q <= req_port_i.address_index;
            we_q    <= req_port_i.data_we;
            be_q    <= req_port_i.data_be;
            wdata_q <= req_port_i.data_wdata;
            id_q    <= req_port_i.data_id;
         end
         if (tag_go && !we_q) begin
            rdata_q <= in_range ? mem[word] : '0;
            cnt_q   <= 2'(RD_LATENCY - 1);
         end else if (state == LAT && cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
         end
      end
   end

   // store is deliberately left out of reset
   always_ff @(posedge clk_i) begin
      if (tag_go && we_q && in_range)
         for (int i = 0; i < 8; i++)
            if (be_q[i]) mem[word][8*i +: 8] <= wdata_q[8*i +: 8];
   end

   assign req_port_o = '{
      data_gnt:    gnt,
      data_rvalid: rvalid,
      data_rid:    rvalid ? id_q : 4'd0,
      data_rdata:  rvalid ? rdata_q : 64'd0,
      data_ruser:  1'b0
   };
   assign busy_o = state != IDLE;
   assign err_o  = err;
endmodule

// File: doc/dcache_req_responder.md
DCACHE_REQ_RESPONDER -- requirements
Module: dcache_req_responder

Interface
REQ-001 Parameter CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration.
REQ-002 Parameter NR_WORDS, 512, backing-store depth in 64-bit words, power of two.
REQ-003 Parameter BASE_ADDR, 0, physical base, aligned to NR_WORDS*8.
REQ-004 Parameter RD_LATENCY, 1, cycles from tag phase to rvalid, range 1..4.
REQ-005 clk_i  input  1  clock; single clock domain.
REQ-006 rst_ni  input  1  reset, synchronous, active-low.
REQ-007 req_port_i  input  dcache_req_i_t  request from initiator (address_index, address_tag, data_wdata, data_req, data_we, data_be, data_size, data_id, kill_req, tag_valid).
REQ-008 req_port_o  output  dcache_req_o_t  response to initiator (data_gnt, data_rvalid, data_rid, data_rdata, data_ruser).
REQ-009 busy_o  output  1  high whenever state is not IDLE.
REQ-010 err_o  output  1  one-cycle pulse on out-of-range access.

Function
REQ-011 FSM states SHALL be IDLE, TAG, LAT; one outstanding request maximum.
REQ-012 IDLE: data_gnt = data_req (combinational, same cycle); on gnt latch address_index, data_we, data_be, data_wdata, data_id; go TAG.
REQ-013 data_gnt SHALL be 0 in TAG and LAT.
REQ-014 TAG: tag_valid=0 -> stay TAG; kill_req=1 -> IDLE, no write, no rvalid, no err_o (kill wins over tag_valid same cycle).
REQ-015 TAG with tag_valid=1, kill_req=0: paddr = {address_tag, latched index}; in range iff paddr[PLEN-1:3+log2(NR_WORDS)] equals same bits of BASE_ADDR; word = paddr[3 +: log2(NR_WORDS)].
REQ-016 Write in tag phase: in range -> bytes with data_be[i]=1 updated at end of that cycle; go IDLE; no rvalid for writes.
REQ-017 Read in tag phase: in range -> capture word; go LAT with counter = RD_LATENCY-1.
REQ-018 LAT: counter 0 -> data_rvalid=1 for exactly one cycle with data_rdata=captured word, data_rid=latched data_id, data_ruser=0; go IDLE next cycle; else decrement.
REQ-019 Read rvalid SHALL occur exactly RD_LATENCY cycles after the tag_valid cycle (grant at T, tag at T+1 -> rvalid at T+1+RD_LATENCY).
REQ-020 kill_req in LAT SHALL be ignored; response always delivered (initiator flush relies on it).
REQ-021 Out of range: err_o pulses in tag cycle; read still returns rvalid with rdata=0; write dropped.
REQ-022 Reads SHALL return the full 64-bit word regardless of data_size/data_be.
REQ-023 Write followed immediately by read to same word SHALL return updated data.
REQ-024 New request accepted in IDLE cycle directly after rvalid cycle (no dead cycle beyond IDLE).

Reset
REQ-025 rst_ni=0 at a rising edge SHALL force IDLE, counter 0, latched fields 0, regardless of state; pending write/response discarded.
REQ-026 Reset values: data_gnt 0, data_rvalid 0, data_rdata 0, data_rid 0, data_ruser 0, busy_o 0, err_o 0.
REQ-027 Backing store contents SHALL not be reset.

Configuration
REQ-028 Macro DCACHE_RESP_GNT_STALL_EN defined: 8-bit LFSR (seed 8'hA5 at reset, taps x^8+x^6+x^5+x^4+1) advances every cycle; gnt in IDLE additionally requires LFSR bit0=0.
REQ-029 Macro undefined: no LFSR logic; gnt per REQ-012.

Verification
REQ-030 Write 0x0000_0000_2000_00CF (be 8'hFF) to BASE_ADDR+0x10, then read it, RD_LATENCY=1 -> gnt same cycle, rvalid 2 cycles after gnt, rdata 0x0000_0000_2000_00CF, rid echoed.
REQ-031 Write be 8'h0F data 0xFFFF_FFFF_1234_5678 over word 0xAAAA_AAAA_BBBB_BBBB -> readback 0xAAAA_AAAA_1234_5678.
REQ-032 Read with kill_req=1 in tag cycle -> no rvalid, busy_o low next cycle, next request granted immediately.
REQ-033 Read at BASE_ADDR + NR_WORDS*8 -> err_o one pulse, rvalid with rdata 0; write there leaves store unchanged.
REQ-034 RD_LATENCY=4, kill_req asserted in LAT -> rvalid still at T+5; rst_ni low during LAT -> no rvalid, all outputs 0.
REQ-035 With DCACHE_RESP_GNT_STALL_EN, 1000 back-to-back reads -> every gnt cycle has LFSR bit0=0, all data correct, no lost or duplicate rvalid.
